// File: rtl/mem_arb_fl_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_fl_pkg
// Shared definitions for the mem_arb_fl data-memory arbiter.
//   - Floating-point word layout (mantissa + exponent + sign) that sets the
//     memory data width.
//   - Arbiter FSM state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package mem_arb_fl_pkg;

    // Data word = mantissa + exponent + sign bit.
    localparam int NBMANT = 16;
    localparam int NBEXPO = 6;
    localparam int NBDATA = NBMANT + NBEXPO + 1;

    // Arbiter state: free round-robin arbitration, or ownership held by one requester.
    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage : mem_arb_fl_pkg

// File: rtl/mem_arb_fl_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches the valid vector starting at
// ptr_i+1 and wrapping modulo NREQ; the first valid index wins.
// Ports:
//   valid_i  in   NREQ          request valid vector
//   ptr_i    in   $clog2(NREQ)  index of the last winner
//   grant_o  out  NREQ          one-hot grant, zero when nothing is valid
//   idx_o    out  $clog2(NREQ)  binary index of the grant (0 when none)
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         valid_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         grant_o,
    output logic [$clog2(NREQ)-1:0] idx_o
);

    localparam int IW = $clog2(NREQ);

    logic found;
    int   j;

    // NOTE: every variable assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && valid_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
            end
        end
    end

endmodule : rr_pick

// File: rtl/mem_arb_fl.sv
// ----------------------------------------------------------------------------
// mem_arb_fl
// Round-robin arbiter sharing one synchronous data-memory port among NREQ
// requesters, with optional locking for atomic multi-access sequences and a
// forced lock release after LOCKMAX cycles.
// Ports:
//   clk        in   1             clock
//   rst        in   1             asynchronous reset, active low
//   req_valid  in   NREQ          request valid per requester
//   req_wr     in   NREQ          1 = write, 0 = read
//   req_lock   in   NREQ          keep ownership after this access
//   req_addr   in   NREQ*MDATAW   address, slice i for requester i
//   req_wdata  in   NREQ*NBDATA   write data, slice i for requester i
//   req_ready  out  NREQ          combinational accept, one-hot or zero
//   rsp_valid  out  NREQ          read-data pulse, one-hot or zero
//   rsp_data   out  NBDATA        read data, qualified by rsp_valid
//   mem_wr     out  1             registered memory write enable
//   mem_addr   out  MDATAW        registered memory address
//   mem_wdata  out  NBDATA        registered memory write data
//   mem_rdata  in   NBDATA        memory read data, one cycle after mem_addr
// Timing: accept at edge t -> mem_* valid in the following cycle; a read's
// rsp_valid pulses one cycle later, while the RAM presents its registered data.
// ----------------------------------------------------------------------------
module mem_arb_fl
    import mem_arb_fl_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MDATAW  = 9,
    parameter int NBDATA  = mem_arb_fl_pkg::NBDATA,
    parameter int LOCKMAX = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_wr,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*MDATAW-1:0]   req_addr,
    input  logic [NREQ*NBDATA-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [NBDATA-1:0]        rsp_data,
    output logic                     mem_wr,
    output logic [MDATAW-1:0]        mem_addr,
    output logic [NBDATA-1:0]        mem_wdata,
    input  logic [NBDATA-1:0]        mem_rdata
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(LOCKMAX);

    // FSM and arbitration state
    arb_state_e      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Issue registers
    logic              mem_wr_q, mem_wr_d;
    logic [MDATAW-1:0] mem_addr_q, mem_addr_d;
    logic [NBDATA-1:0] mem_wdata_q, mem_wdata_d;

    // Two-stage read tag pipe {valid, id}
    logic            tag1_vld_q, tag1_vld_d;
    logic [IW-1:0]   tag1_id_q, tag1_id_d;
    logic            tag2_vld_q;
    logic [IW-1:0]   tag2_id_q;

    // Picker and handshake
    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] ready;
    logic [IW-1:0]   acc_idx;
    logic            accept;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    // Grant generation. While locked only the owner can be accepted, and only
    // when it is actually valid, so ready never points at an idle requester.
    always_comb begin
        ready   = '0;
        acc_idx = pick_idx;
        if (!rst) begin
            ready = '0;
        end else if (state_q == ARB) begin
            ready = pick_grant;
        end else begin
            acc_idx        = owner_q;
            ready[owner_q] = req_valid[owner_q];
        end
    end

    assign req_ready = ready;
    assign accept    = |(req_valid & ready);

    // Next-state logic for the arbitration FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB: begin
                if (accept) begin
                    ptr_d = acc_idx;
                    if (req_lock[acc_idx]) begin
                        state_d = LOCK;
                        owner_d = acc_idx;
                        cnt_d   = '0;
                    end
                end
            end
            LOCK: begin
                // The counter runs whether or not the owner is using the port,
                // so an owner that goes quiet still loses the lock.
                cnt_d = cnt_q + CW'(1);
                if (accept) begin
                    ptr_d = acc_idx;
                end
                if ((cnt_q == CW'(LOCKMAX - 1)) || (accept && !req_lock[owner_q])) begin
                    state_d = ARB;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    // Issue and tag next-state. Address/data hold when idle; write enable is
    // a single-cycle pulse.
    always_comb begin
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tag1_vld_d  = 1'b0;
        tag1_id_d   = tag1_id_q;
        if (accept) begin
            mem_wr_d    = req_wr[acc_idx];
            mem_addr_d  = req_addr[int'(acc_idx)*MDATAW +: MDATAW];
            mem_wdata_d = req_wdata[int'(acc_idx)*NBDATA +: NBDATA];
            tag1_vld_d  = !req_wr[acc_idx];
            tag1_id_d   = acc_idx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB;
            ptr_q   <= IW'(NREQ - 1);
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath registers. Reset clears the tag pipe, which drops any read in
    // flight so no response follows a reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag1_vld_q  <= 1'b0;
            tag1_id_q   <= '0;
            tag2_vld_q  <= 1'b0;
            tag2_id_q   <= '0;
        end else begin
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tag1_vld_q  <= tag1_vld_d;
            tag1_id_q   <= tag1_id_d;
            tag2_vld_q  <= tag1_vld_q;
            tag2_id_q   <= tag1_id_q;
        end
    end

    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Response decode from the registered second tag stage. The RAM's own
    // output register supplies the data in the same cycle.
    always_comb begin
        rsp_valid = '0;
        if (tag2_vld_q) begin
            rsp_valid[tag2_id_q] = 1'b1;
        end
    end

    assign rsp_data = mem_rdata;

endmodule : mem_arb_fl
